// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the M-extension execute stage: op codes, sequencer states and
// divide iteration constants.
package muldiv_sequencer_pkg;

   typedef enum logic [3:0] {
      MD_MUL    = 4'd0,
      MD_MULH   = 4'd1,
      MD_MULHSU = 4'd2,
      MD_MULHU  = 4'd3,
      MD_DIV    = 4'd4,
      MD_DIVU   = 4'd5,
      MD_REM    = 4'd6,
      MD_REMU   = 4'd7
   } MulDivCode;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
      FIX,
      DONE
   } MulDivSeqState;

   localparam int unsigned DIV_ITERATIONS = 32;
   localparam int unsigned DIV_COUNT_W    = $clog2(DIV_ITERATIONS);

   function automatic logic isDivCode(MulDivCode code);
      return code inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
   endfunction

   function automatic logic isSignedDivCode(MulDivCode code);
      return code inside {MD_DIV, MD_REM};
   endfunction

   function automatic logic isRemCode(MulDivCode code);
      return code inside {MD_REM, MD_REMU};
   endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Issue-side and writeback-side handshake bundle of the mul/div sequencer.
interface muldiv_sequencer_if #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned TAG_WIDTH = 5
) ();
   import muldiv_sequencer_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   MulDivCode            in_code;
   logic [XLEN-1:0]      in_op1;
   logic [XLEN-1:0]      in_op2;
   logic [TAG_WIDTH-1:0] in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      out_result;
   logic [TAG_WIDTH-1:0] out_tag;

   modport master (
      output in_valid, in_code, in_op1, in_op2, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag
   );

   modport slave (
      input  in_valid, in_code, in_op1, in_op2, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag
   );

endinterface

// File: rtl/muldiv_sequencer_div_step.sv
// One radix-2 restoring divide iteration: shift {rem,quo} left, subtract the
// divisor when it fits and record the quotient bit.
module div_step (
   input  logic [31:0] rem,
   input  logic [31:0] quo,
   input  logic [31:0] divisor,
   output logic [31:0] rem_next,
   output logic [31:0] quo_next
);

   logic [32:0] shifted;
   logic        fits;

   always_comb begin
      shifted  = {rem, quo[31]};
      fits     = (shifted >= {1'b0, divisor});
      // the true difference is below the divisor, so 32-bit wraparound is exact
      rem_next = fits ? (shifted[31:0] - divisor) : shifted[31:0];
      quo_next = {quo[30:0], fits};
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle M-extension execute stage: registered multiply, iterative restoring
// divide, result held with its tag until writeback accepts it.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned TAG_WIDTH = 5
) (
   input logic               clk,
   input logic               rst,
   input logic               flush,
   muldiv_sequencer_if.slave bus
);

   MulDivSeqState          state;
   MulDivSeqState          state_next;
   MulDivCode              code_q;
   logic [XLEN-1:0]        op1_q;
   logic [XLEN-1:0]        op2_q;
   logic [XLEN-1:0]        rem_q;
   logic [XLEN-1:0]        quo_q;
   logic [XLEN-1:0]        divisor_q;
   logic [DIV_COUNT_W-1:0] count_q;
   logic                   quo_neg_q;
   logic                   rem_neg_q;
   logic [XLEN-1:0]        result_q;
   logic [TAG_WIDTH-1:0]   tag_q;

   logic                   accept;
   logic                   in_div;
   logic                   in_signed;
   logic                   in_rem;
   logic                   div_by_zero;
   logic                   div_overflow;
   logic                   div_special;
   logic [XLEN-1:0]        special_result;
   logic [XLEN-1:0]        op1_mag;
   logic [XLEN-1:0]        op2_mag;
   logic                   last_iter;

   logic [2*XLEN-1:0]      mul_a;
   logic [2*XLEN-1:0]      mul_b;
   logic [2*XLEN-1:0]      mul_prod;
   logic [XLEN-1:0]        mul_result;
   logic [XLEN-1:0]        quo_fix;
   logic [XLEN-1:0]        rem_fix;
   logic [XLEN-1:0]        fix_result;
   logic [XLEN-1:0]        step_rem;
   logic [XLEN-1:0]        step_quo;

   assign accept    = bus.in_valid && bus.in_ready && !flush;
   assign last_iter = (count_q == DIV_COUNT_W'(DIV_ITERATIONS - 1));

   // Issue-time decode: divide special cases resolve here and skip the iterations.
   always_comb begin
      in_div         = isDivCode(bus.in_code);
      in_signed      = isSignedDivCode(bus.in_code);
      in_rem         = isRemCode(bus.in_code);
      div_by_zero    = (bus.in_op2 == '0);
      div_overflow   = in_signed && (bus.in_op1 == {1'b1, {(XLEN-1){1'b0}}})
                       && (bus.in_op2 == '1);
      div_special    = in_div && (div_by_zero || div_overflow);
      special_result = '0;
      if (div_by_zero)
         special_result = in_rem ? bus.in_op1 : '1;
      else if (div_overflow)
         special_result = in_rem ? '0 : bus.in_op1;
      op1_mag = (in_signed && bus.in_op1[XLEN-1]) ? (-bus.in_op1) : bus.in_op1;
      op2_mag = (in_signed && bus.in_op2[XLEN-1]) ? (-bus.in_op2) : bus.in_op2;
   end

   // Operands sign-extended to 2*XLEN; the low 2*XLEN product bits equal the
   // 33x33 signed product, so one unsigned multiplier covers every MUL variant.
   always_comb begin
      mul_a    = {{XLEN{(code_q inside {MD_MUL, MD_MULH, MD_MULHSU}) & op1_q[XLEN-1]}}, op1_q};
      mul_b    = {{XLEN{(code_q inside {MD_MUL, MD_MULH}) & op2_q[XLEN-1]}}, op2_q};
      mul_prod = mul_a * mul_b;
      case (code_q)
         MD_MUL:                       mul_result = mul_prod[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: mul_result = mul_prod[2*XLEN-1:XLEN];
         default:                      mul_result = '0;
      endcase
   end

   always_comb begin
      quo_fix    = quo_neg_q ? (-quo_q) : quo_q;
      rem_fix    = rem_neg_q ? (-rem_q) : rem_q;
      fix_result = isRemCode(code_q) ? rem_fix : quo_fix;
   end

   div_step u_div_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (divisor_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (!in_div)
                     state_next = MUL;
                  else if (div_special)
                     state_next = DONE;
                  else
                     state_next = DIV;
               end
            end
            MUL:     state_next = DONE;
            DIV:     if (last_iter) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.in_ready   = (state == IDLE);
      bus.out_valid  = (state == DONE);
      bus.out_result = result_q;
      bus.out_tag    = tag_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_q    <= MD_MUL;
         op1_q     <= '0;
         op2_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         count_q   <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         result_q  <= '0;
         tag_q     <= '0;
      end else if (accept) begin
         code_q    <= bus.in_code;
         op1_q     <= bus.in_op1;
         op2_q     <= bus.in_op2;
         tag_q     <= bus.in_tag;
         rem_q     <= '0;
         quo_q     <= op1_mag;
         divisor_q <= op2_mag;
         count_q   <= '0;
         quo_neg_q <= in_signed & (bus.in_op1[XLEN-1] ^ bus.in_op2[XLEN-1]);
         rem_neg_q <= in_signed & bus.in_op1[XLEN-1];
         if (div_special)
            result_q <= special_result;
      end else begin
         case (state)
            MUL: result_q <= mul_result;
            DIV: begin
               rem_q   <= step_rem;
               quo_q   <= step_quo;
               count_q <= count_q + 1'b1;
            end
            FIX: result_q <= fix_result;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: latency, results, specials,
// backpressure, flush and asynchronous reset.
module tb_muldiv_sequencer;
   import muldiv_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   checks = 0;
   int   errors = 0;

   muldiv_sequencer_if #(.XLEN(32), .TAG_WIDTH(5)) bus ();

   muldiv_sequencer #(.XLEN(32), .TAG_WIDTH(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic issue(input MulDivCode c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_code  = c;
      bus.in_op1   = a;
      bus.in_op2   = b;
      bus.in_tag   = t;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   // Latency in cycles after the accept cycle; 0 means the bound expired.
   task automatic wait_valid(output int lat);
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic do_op(input string name, input MulDivCode c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t,
                        input logic [31:0] exp, input int exp_lat);
      int lat;
      issue(c, a, b, t);
      wait_valid(lat);
      chk({name, " latency"}, lat, exp_lat);
      chk({name, " result"}, bus.out_result, exp);
      chk({name, " tag"}, {27'b0, bus.out_tag}, {27'b0, t});
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  lat;
      logic seen_valid;
      rst           = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_code   = MD_MUL;
      bus.in_op1    = '0;
      bus.in_op2    = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready",   {31'b0, bus.in_ready},  32'd1);
      chk("reset out_valid",  {31'b0, bus.out_valid}, 32'd0);
      chk("reset out_result", bus.out_result,         32'd0);
      chk("reset out_tag",    {27'b0, bus.out_tag},   32'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op("MUL 7*-3",      MD_MUL,    32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 2);
      do_op("MULHU max",     MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 2);
      do_op("MULH -1*-1",    MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 2);
      do_op("MULHSU -1*max", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 2);
      do_op("bad code",      MulDivCode'(4'd10), 32'd5, 32'd6,        5'd7,  32'h0000_0000, 2);

      do_op("DIV -7/2",      MD_DIV,    32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, 34);
      do_op("REM -7/2",      MD_REM,    32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF, 34);
      do_op("DIVU 100/7",    MD_DIVU,   32'd100,      32'd7,          5'd10, 32'd14,        34);
      do_op("REMU 100/7",    MD_REMU,   32'd100,      32'd7,          5'd11, 32'd2,         34);
      do_op("REM 7/-2",      MD_REM,    32'd7,        32'hFFFF_FFFE,  5'd12, 32'd1,         34);

      do_op("DIV x/0",       MD_DIV,    32'd123,      32'd0,          5'd13, 32'hFFFF_FFFF, 1);
      do_op("REMU 5/0",      MD_REMU,   32'd5,        32'd0,          5'd14, 32'd5,         1);
      do_op("DIV ovf",       MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
      do_op("REM ovf",       MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1);

      // Backpressure: result must hold for 10 cycles with out_ready low.
      bus.out_ready = 1'b0;
      issue(MD_DIVU, 32'd100, 32'd7, 5'd17);
      wait_valid(lat);
      chk("bp latency", lat, 34);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp out_valid", {31'b0, bus.out_valid}, 32'd1);
         chk("bp result",    bus.out_result,         32'd14);
         chk("bp tag",       {27'b0, bus.out_tag},   32'd17);
         chk("bp in_ready",  {31'b0, bus.in_ready},  32'd0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp drain in_ready",  {31'b0, bus.in_ready},  32'd1);
      chk("bp drain out_valid", {31'b0, bus.out_valid}, 32'd0);

      // Flush in cycle c+10 of a divide.
      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 5'd18);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush in_ready", {31'b0, bus.in_ready}, 32'd1);
      seen_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
      end
      chk("flush no out_valid", {31'b0, seen_valid}, 32'd0);
      do_op("MUL 3*4 after flush", MD_MUL, 32'd3, 32'd4, 5'd19, 32'd12, 2);

      // Asynchronous reset mid-divide, checked between clock edges.
      issue(MD_DIV, 32'd1000, 32'd3, 5'd21);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async rst in_ready",   {31'b0, bus.in_ready},  32'd1);
      chk("async rst out_valid",  {31'b0, bus.out_valid}, 32'd0);
      chk("async rst out_result", bus.out_result,         32'd0);
      chk("async rst out_tag",    {27'b0, bus.out_tag},   32'd0);
      #2 rst = 1'b0;
      do_op("DIVU 9/3 after rst", MD_DIVU, 32'd9, 32'd3, 5'd22, 32'd3, 34);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
